// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory stage: control structs, FSM state, funct3 codes.
// Also holds the store byte-enable helper used by mem_stage.
package mem_stage_pkg;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_control_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       jump;
  } wb_control_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Low address bits beyond the access size are ignored (SH at offset 3 uses half 1).
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between mem_stage (master) and the memory (slave).
// Handshake: master holds dmem_req with stable we/addr/be/wdata until the cycle dmem_ack is
// high; that cycle completes the access and dmem_rdata is valid in it. Ack without req is ignored.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load formatter: picks the addressed byte/half from a read word and sign- or zero-extends it.
// Purely combinational; unknown funct3 codes return the raw word.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*off +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      F3_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB pipeline register; stalls upstream while an access waits for ack.
// Optional macro MEM_MISALIGN_TRAP_EN: flag misaligned H/W accesses via misalign_exc instead of issuing.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic [XLEN-1:0]   pc_offset_in,
  input  logic [XLEN-1:0]   immediate_in,
  input  logic [XLEN-1:0]   pc_incr_in,
  input  mem_control_t      mem_ctrl_in,
  input  wb_control_t       wb_ctrl_in,
  input  logic [4:0]        rd_addr_in,
  mem_stage_if.master       dmem,
  output logic              mem_stall,
  output logic              out_valid,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [XLEN-1:0]   data_out,
  output logic [XLEN-1:0]   pc_offset_out,
  output logic [XLEN-1:0]   immediate_out,
  output logic [XLEN-1:0]   pc_incr_out,
  output wb_control_t       wb_ctrl_out,
  output logic [4:0]        rd_addr_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_exc,
`endif
  output mem_state_e        state_dbg
);

  mem_state_e        state;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [3:0]        cap_be;
  logic [XLEN-1:0]   cap_wdata;
  logic [2:0]        cap_funct3;

  logic              mem_op, misaligned, issue, in_wait, is_store, is_load;
  logic [1:0]        off_in;
  logic [3:0]        be_in;
  logic [XLEN-1:0]   wdata_in, load_data;
  logic [ADDR_W-1:0] addr_in;

  assign addr_in  = alu_result_in[ADDR_W-1:0];
  assign off_in   = alu_result_in[1:0];
  assign mem_op   = in_valid & (mem_ctrl_in.mem_read | mem_ctrl_in.mem_write);
  assign is_store = mem_ctrl_in.mem_write;
  assign in_wait  = (state == WAIT);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op &
                      (((mem_ctrl_in.funct3[1:0] == 2'b01) & off_in[0]) |
                       ((mem_ctrl_in.funct3[1:0] == 2'b10) & (off_in != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign issue   = mem_op & ~misaligned;
  assign is_load = in_valid & mem_ctrl_in.mem_read & ~mem_ctrl_in.mem_write & ~misaligned;
  assign be_in   = is_store ? store_be(mem_ctrl_in.funct3, off_in) : 4'b1111;

  always_comb begin
    case (mem_ctrl_in.funct3[1:0])
      2'b00:   wdata_in = {4{rs2_data_in[7:0]}};
      2'b01:   wdata_in = {2{rs2_data_in[15:0]}};
      default: wdata_in = rs2_data_in;
    endcase
  end

  // In WAIT the port is driven only from captured values so it stays stable until ack.
  assign dmem.dmem_req   = ~rst & (in_wait | issue);
  assign dmem.dmem_we    = in_wait ? cap_we : is_store;
  assign dmem.dmem_addr  = in_wait ? {cap_addr[ADDR_W-1:2], 2'b00} : {addr_in[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_be    = in_wait ? cap_be : be_in;
  assign dmem.dmem_wdata = in_wait ? cap_wdata : wdata_in;

  assign mem_stall = ~rst & ((~in_wait & issue & ~dmem.dmem_ack) | (in_wait & ~dmem.dmem_ack));
  assign state_dbg = state;

  mem_load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .off    (in_wait ? cap_addr[1:0] : off_in),
    .funct3 (in_wait ? cap_funct3 : mem_ctrl_in.funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cap_addr       <= '0;
      cap_we         <= 1'b0;
      cap_be         <= 4'b0;
      cap_wdata      <= '0;
      cap_funct3     <= 3'b0;
      out_valid      <= 1'b0;
      alu_result_out <= '0;
      data_out       <= '0;
      pc_offset_out  <= '0;
      immediate_out  <= '0;
      pc_incr_out    <= '0;
      wb_ctrl_out    <= '0;
      rd_addr_out    <= 5'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_exc   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (issue & ~dmem.dmem_ack) begin
            state      <= WAIT;
            cap_addr   <= addr_in;
            cap_we     <= is_store;
            cap_be     <= be_in;
            cap_wdata  <= wdata_in;
            cap_funct3 <= mem_ctrl_in.funct3;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (!mem_stall) begin
        out_valid             <= in_valid;
        alu_result_out        <= alu_result_in;
        data_out              <= is_load ? load_data : '0;
        pc_offset_out         <= pc_offset_in;
        immediate_out         <= immediate_in;
        pc_incr_out           <= pc_incr_in;
        wb_ctrl_out           <= wb_ctrl_in;
        wb_ctrl_out.reg_write <= wb_ctrl_in.reg_write & in_valid & ~misaligned;
        rd_addr_out           <= rd_addr_in;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_exc          <= in_valid & misaligned;
`endif
      end else begin
        // Bubble into WB; payload holds, but nothing may be written back.
        out_valid             <= 1'b0;
        wb_ctrl_out.reg_write <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_exc          <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, pass-through, stalls, reset mid-access.
// Build with MEM_MISALIGN_TRAP_EN defined to also cover the misalignment trap.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [31:0]  alu_result_in, rs2_data_in, pc_offset_in, immediate_in, pc_incr_in;
  mem_control_t mem_ctrl_in;
  wb_control_t  wb_ctrl_in;
  logic [4:0]   rd_addr_in;
  logic         mem_stall, out_valid;
  logic [31:0]  alu_result_out, data_out, pc_offset_out, immediate_out, pc_incr_out;
  wb_control_t  wb_ctrl_out;
  logic [4:0]   rd_addr_out;
  mem_state_e   state_dbg;
`ifdef MEM_MISALIGN_TRAP_EN
  logic         misalign_exc;
`endif

  logic [31:0]  ref_rdata, ref_data;
  logic [1:0]   ref_off;
  logic [2:0]   ref_f3;

  int pass_cnt  = 0;
  int check_cnt = 0;

  mem_stage_if #(.ADDR_W(32)) dmem ();

  mem_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .alu_result_in  (alu_result_in),
    .rs2_data_in    (rs2_data_in),
    .pc_offset_in   (pc_offset_in),
    .immediate_in   (immediate_in),
    .pc_incr_in     (pc_incr_in),
    .mem_ctrl_in    (mem_ctrl_in),
    .wb_ctrl_in     (wb_ctrl_in),
    .rd_addr_in     (rd_addr_in),
    .dmem           (dmem),
    .mem_stall      (mem_stall),
    .out_valid      (out_valid),
    .alu_result_out (alu_result_out),
    .data_out       (data_out),
    .pc_offset_out  (pc_offset_out),
    .immediate_out  (immediate_out),
    .pc_incr_out    (pc_incr_out),
    .wb_ctrl_out    (wb_ctrl_out),
    .rd_addr_out    (rd_addr_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_exc   (misalign_exc),
`endif
    .state_dbg      (state_dbg)
  );

  mem_load_align ref_align (
    .rdata  (ref_rdata),
    .off    (ref_off),
    .funct3 (ref_f3),
    .data   (ref_data)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [3:0] wb,
                        input logic [4:0] rda);
    in_valid              = v;
    mem_ctrl_in.mem_read  = rd;
    mem_ctrl_in.mem_write = wr;
    mem_ctrl_in.funct3    = f3;
    alu_result_in         = alu;
    rs2_data_in           = rs2;
    wb_ctrl_in            = wb;
    rd_addr_in            = rda;
  endtask

  task automatic set_mem(input logic ack, input logic [31:0] rdata);
    dmem.dmem_ack   = ack;
    dmem.dmem_rdata = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_check(input string tag, input logic [31:0] rdata, input logic [1:0] off,
                           input logic [2:0] f3, input logic [31:0] exp);
    ref_rdata = rdata;
    ref_off   = off;
    ref_f3    = f3;
    #1;
    check(tag, ref_data, exp);
  endtask

  initial begin
    rst          = 1'b1;
    pc_offset_in = 32'h0;
    immediate_in = 32'h0;
    pc_incr_in   = 32'h0;
    set_op(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0, 4'h0, 5'd0);
    set_mem(1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_req", 32'(dmem.dmem_req), 32'h0);
    check("rst_stall", 32'(mem_stall), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_alu", alu_result_out, 32'h0);
    check("rst_data", data_out, 32'h0);
    check("rst_wb", 32'(wb_ctrl_out), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    // Load formatter reference vectors
    ref_check("ref_lb_neg", 32'h80FF0000, 2'd3, F3_B, 32'hFFFFFF80);
    ref_check("ref_lbu", 32'h80FF0000, 2'd2, F3_BU, 32'h000000FF);
    ref_check("ref_lh_hi", 32'hBEEF1234, 2'd2, F3_H, 32'hFFFFBEEF);
    ref_check("ref_lhu_lo", 32'hBEEF1234, 2'd0, F3_HU, 32'h00001234);
    ref_check("ref_lw", 32'hBEEF1234, 2'd1, F3_W, 32'hBEEF1234);
    ref_check("ref_raw", 32'h12345678, 2'd1, 3'b011, 32'h12345678);

    // LW 0x100, ack same cycle
    next_cycle();
    set_op(1'b1, 1'b1, 1'b0, F3_W, 32'h100, 32'h0, 4'hA, 5'd5);
    pc_incr_in = 32'h44;
    set_mem(1'b1, 32'hDEADBEEF);
    #1;
    check("lw_req", 32'(dmem.dmem_req), 32'h1);
    check("lw_stall", 32'(mem_stall), 32'h0);
    check("lw_addr", dmem.dmem_addr, 32'h100);
    check("lw_we", 32'(dmem.dmem_we), 32'h0);
    check("lw_be", 32'(dmem.dmem_be), 32'hF);
    next_cycle();
    check("lw_valid", 32'(out_valid), 32'h1);
    check("lw_data", data_out, 32'hDEADBEEF);
    check("lw_rd", 32'(rd_addr_out), 32'd5);
    check("lw_wb", 32'(wb_ctrl_out), 32'hA);
    check("lw_pc4", pc_incr_out, 32'h44);

    // LB 0x103 back-to-back, ack after 3 stall cycles
    set_op(1'b1, 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 4'hA, 5'd6);
    set_mem(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lb_stall", 32'(mem_stall), 32'h1);
      check("lb_req", 32'(dmem.dmem_req), 32'h1);
      check("lb_addr", dmem.dmem_addr, 32'h100);
      next_cycle();
      check("lb_bubble", 32'(out_valid), 32'h0);
      check("lb_bubble_rw", 32'(wb_ctrl_out.reg_write), 32'h0);
      check("lb_hold_alu", alu_result_out, 32'h100);
      check("lb_state", 32'(state_dbg), 32'(WAIT));
    end
    set_mem(1'b1, 32'h80FF0000);
    #1;
    check("lb_ack_stall", 32'(mem_stall), 32'h0);
    next_cycle();
    check("lb_valid", 32'(out_valid), 32'h1);
    check("lb_data", data_out, 32'hFFFFFF80);
    check("lb_rd", 32'(rd_addr_out), 32'd6);
    check("lb_state_idle", 32'(state_dbg), 32'(IDLE));

    // LBU of the same byte, ack same cycle
    set_op(1'b1, 1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 4'hA, 5'd6);
    #1;
    check("lbu_stall", 32'(mem_stall), 32'h0);
    next_cycle();
    check("lbu_data", data_out, 32'h00000080);

    // LH at offset 3 uses half 1 when misalignment is not trapped
`ifndef MEM_MISALIGN_TRAP_EN
    set_op(1'b1, 1'b1, 1'b0, F3_H, 32'h103, 32'h0, 4'hA, 5'd7);
    set_mem(1'b1, 32'hBEEF1234);
    next_cycle();
    check("lh_mis_data", data_out, 32'hFFFFBEEF);
`endif

    // SH 0x202, wait one cycle; port must stay stable even if inputs wiggle
    set_op(1'b1, 1'b0, 1'b1, F3_H, 32'h202, 32'h1234ABCD, 4'h0, 5'd0);
    set_mem(1'b0, 32'h0);
    #1;
    check("sh_be", 32'(dmem.dmem_be), 32'hC);
    check("sh_wdata", dmem.dmem_wdata, 32'hABCDABCD);
    check("sh_we", 32'(dmem.dmem_we), 32'h1);
    check("sh_addr", dmem.dmem_addr, 32'h200);
    check("sh_stall", 32'(mem_stall), 32'h1);
    next_cycle();
    alu_result_in = 32'h3FC;
    rs2_data_in   = 32'h0;
    #1;
    check("sh_wait_addr", dmem.dmem_addr, 32'h200);
    check("sh_wait_wdata", dmem.dmem_wdata, 32'hABCDABCD);
    check("sh_wait_be", 32'(dmem.dmem_be), 32'hC);
    check("sh_wait_we", 32'(dmem.dmem_we), 32'h1);
    alu_result_in = 32'h202;
    rs2_data_in   = 32'h1234ABCD;
    set_mem(1'b1, 32'hFFFFFFFF);
    next_cycle();
    check("sh_valid", 32'(out_valid), 32'h1);
    check("sh_data", data_out, 32'h0);
    check("sh_alu", alu_result_out, 32'h202);

    // SB offset 1 and SW, ack same cycle
    set_op(1'b1, 1'b0, 1'b1, F3_B, 32'h301, 32'h1234ABCD, 4'h0, 5'd0);
    #1;
    check("sb_be", 32'(dmem.dmem_be), 32'h2);
    check("sb_wdata", dmem.dmem_wdata, 32'hCDCDCDCD);
    next_cycle();
    set_op(1'b1, 1'b0, 1'b1, F3_W, 32'h304, 32'hCAFEF00D, 4'h0, 5'd0);
    #1;
    check("sw_be", 32'(dmem.dmem_be), 32'hF);
    check("sw_wdata", dmem.dmem_wdata, 32'hCAFEF00D);
    next_cycle();

    // ADD pass-through
    set_op(1'b1, 1'b0, 1'b0, F3_B, 32'h55, 32'h0, 4'h8, 5'd9);
    set_mem(1'b0, 32'h0);
    pc_offset_in = 32'h1000;
    immediate_in = 32'h2000;
    pc_incr_in   = 32'h88;
    #1;
    check("add_req", 32'(dmem.dmem_req), 32'h0);
    check("add_stall", 32'(mem_stall), 32'h0);
    next_cycle();
    check("add_valid", 32'(out_valid), 32'h1);
    check("add_alu", alu_result_out, 32'h55);
    check("add_data", data_out, 32'h0);
    check("add_pcoff", pc_offset_out, 32'h1000);
    check("add_imm", immediate_out, 32'h2000);
    check("add_pc4", pc_incr_out, 32'h88);
    check("add_wb", 32'(wb_ctrl_out), 32'h8);
    check("add_rd", 32'(rd_addr_out), 32'd9);

    // Invalid slot with MemRead set must not request
    set_op(1'b0, 1'b1, 1'b0, F3_W, 32'h400, 32'h0, 4'h8, 5'd3);
    #1;
    check("inv_req", 32'(dmem.dmem_req), 32'h0);
    next_cycle();
    check("inv_valid", 32'(out_valid), 32'h0);
    check("inv_rw", 32'(wb_ctrl_out.reg_write), 32'h0);

    // Reset while in WAIT, then late ack
    set_op(1'b1, 1'b1, 1'b0, F3_W, 32'h300, 32'h0, 4'hA, 5'd4);
    next_cycle();
    check("rw_state", 32'(state_dbg), 32'(WAIT));
    rst = 1'b1;
    #1;
    check("rw_req_rst", 32'(dmem.dmem_req), 32'h0);
    check("rw_stall_rst", 32'(mem_stall), 32'h0);
    next_cycle();
    check("rw_state_idle", 32'(state_dbg), 32'(IDLE));
    check("rw_valid", 32'(out_valid), 32'h0);
    check("rw_alu", alu_result_out, 32'h0);
    check("rw_pc4", pc_incr_out, 32'h0);
    check("rw_wb", 32'(wb_ctrl_out), 32'h0);
    rst = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0, 4'h0, 5'd0);
    set_mem(1'b1, 32'h55555555);
    #1;
    check("late_req", 32'(dmem.dmem_req), 32'h0);
    check("late_stall", 32'(mem_stall), 32'h0);
    next_cycle();
    check("late_state", 32'(state_dbg), 32'(IDLE));
    check("late_valid", 32'(out_valid), 32'h0);
    set_op(1'b1, 1'b1, 1'b0, F3_W, 32'h104, 32'h0, 4'hA, 5'd2);
    set_mem(1'b1, 32'h11223344);
    #1;
    check("post_req", 32'(dmem.dmem_req), 32'h1);
    check("post_addr", dmem.dmem_addr, 32'h104);
    next_cycle();
    check("post_data", data_out, 32'h11223344);
    check("post_valid", 32'(out_valid), 32'h1);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned LW is trapped, not issued
    set_op(1'b1, 1'b1, 1'b0, F3_W, 32'h101, 32'h0, 4'hA, 5'd8);
    set_mem(1'b0, 32'h0);
    #1;
    check("mis_req", 32'(dmem.dmem_req), 32'h0);
    check("mis_stall", 32'(mem_stall), 32'h0);
    next_cycle();
    check("mis_exc", 32'(misalign_exc), 32'h1);
    check("mis_valid", 32'(out_valid), 32'h1);
    check("mis_rw", 32'(wb_ctrl_out.reg_write), 32'h0);
    set_op(1'b1, 1'b1, 1'b0, F3_H, 32'h102, 32'h0, 4'hA, 5'd8);
    set_mem(1'b1, 32'hBEEF1234);
    #1;
    check("al_req", 32'(dmem.dmem_req), 32'h1);
    next_cycle();
    check("al_exc", 32'(misalign_exc), 32'h0);
    check("al_data", data_out, 32'hFFFFBEEF);
`endif

    set_op(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0, 4'h0, 5'd0);
    set_mem(1'b0, 32'h0);
    next_cycle();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register.
- Takes EX/MEM results and performs loads and stores over a req/ack data-memory port.
- Aligns and sign- or zero-extends load data.
- Registers everything the write-back stage consumes: ALU result, load data, PC offset, immediate, PC+4, write-back control, rd address.
- Stalls the pipeline while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- alu_result_in  in  32  effective address / ALU result
- rs2_data_in  in  32  store data
- pc_offset_in  in  32  PC+imm (auipc)
- immediate_in  in  32  immediate (lui)
- pc_incr_in  in  32  PC+4
- mem_ctrl_in  in  mem_control_t  MemRead, MemWrite, funct3[2:0]
- wb_ctrl_in  in  wb_control_t  RegWrite, MemtoReg[1:0], Jump
- rd_addr_in  in  5  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  freeze IF/ID/EX and hold EX/MEM inputs
- out_valid  out  1  MEM/WB slot valid
- alu_result_out, data_out, pc_offset_out, immediate_out, pc_incr_out  out  32 each  registered to WB
- wb_ctrl_out  out  wb_control_t  registered to WB; RegWrite forced 0 when out_valid=0
- rd_addr_out  out  5  registered to WB

Behaviour:
- Memory-op condition: mem_op = in_valid & (MemRead | MemWrite). MemRead and MemWrite are never both 1; if both are, the access is treated as a store.
- FSM states: IDLE, WAIT.
- IDLE:
  - dmem_req = mem_op (combinational from inputs).
  - If dmem_ack arrives the same cycle, the access completes with zero stall.
  - If mem_op & !dmem_ack, go to WAIT and capture addr, we, be, wdata and funct3 into internal registers.
- WAIT:
  - dmem_req=1, driven from the captured registers; stable until ack.
  - On dmem_ack, return to IDLE.
- Stall: mem_stall = (IDLE & mem_op & !dmem_ack) | (WAIT & !dmem_ack). Upstream holds its inputs while mem_stall=1.
- MEM/WB register update when mem_stall=0:
  - All *_out registers load their *_in values.
  - out_valid <= in_valid.
  - data_out <= the formatted load value; 0 for non-loads.
- MEM/WB register when mem_stall=1: out_valid <= 0 (bubble) and the other out registers hold. Load latency is 1 cycle after the ack cycle.
- Store byte enables:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111, we=0.
- Load formatting from dmem_rdata and addr[1:0]:
  - LB/LBU (000/100): select byte addr[1:0]; sign-extend / zero-extend.
  - LH/LHU (001/101): select half addr[1]; sign-extend / zero-extend.
  - LW (010): word unchanged.
  - Any other funct3 returns the raw word.
- Misalignment without the optional feature: addr low bits are ignored within the access size (SH at offset 3 uses half 1; SW/LW uses the word).
- Reset: state <= IDLE; every *_out register = 0; out_valid=0; wb_ctrl_out all 0.
- Reset mid-operation: reset in WAIT abandons the access. dmem_req and mem_stall are forced 0 while rst=1. A late dmem_ack after reset is ignored.
- Non-memory instructions pass through with zero stall.
- Back-to-back memory ops are allowed: the ack cycle of one and the IDLE request of the next are in consecutive cycles.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 set misaligned=1.
  - dmem_req is suppressed and there is no stall.
  - An extra output misalign_exc (1 bit, registered alongside out_valid) is asserted.
  - wb_ctrl_out.RegWrite is forced 0 for that slot.
- Undefined: the port is absent and the misalignment behaviour above applies.

Decomposition:
- Shared pipeline package holds:
  - mem_control_t and the existing wb_control_t;
  - a mem_state_e enum (IDLE, WAIT);
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module mem_load_align: combinational (rdata, addr[1:0], funct3) -> 32-bit formatted load value; reused by the bench as a reference model.

Test Plan:
- LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall; next cycle out_valid=1, data_out=0xDEADBEEF.
- LB addr 0x103, ack after 3 cycles, rdata 0x80FF_0000 -> mem_stall high 3 cycles, 3 bubbles (out_valid=0), then data_out=0xFFFFFF80; LBU of the same -> 0x00000080.
- SH addr 0x202, rs2 0x1234ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_addr=0x200.
- ADD result 0x55, MemtoReg=0, no mem op -> dmem_req=0, no stall, alu_result_out=0x55 one cycle later.
- rst asserted in WAIT, then a late dmem_ack -> state IDLE, all outputs 0, ack ignored, next LW issues normally.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x101 -> dmem_req=0, misalign_exc=1, RegWrite_out=0.
